// File: rtl/mips_div_sequencer_pkg.sv
// Shared types and constants for the DIV/DIVU sequencer.
// The state enum, datapath width and divide-by-zero quotient are used by both RTL and bench.
package mips_div_sequencer_pkg;

    localparam int DIV_WIDTH = 32;
    localparam logic [DIV_WIDTH-1:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } div_state_t;

    // Two's-complement negate when neg is set; |0x80000000| stays 0x80000000 as an unsigned magnitude.
    function automatic logic [DIV_WIDTH-1:0] cond_neg(input logic [DIV_WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/mips_div_sequencer_if.sv
// CPU-side request/result bundle for the divide sequencer.
// master = execute stage driving requests; slave = the sequencer.
interface mips_div_sequencer_if;
    import mips_div_sequencer_pkg::*;

    logic                 start;
    logic                 is_signed;
    logic [DIV_WIDTH-1:0] dividend;
    logic [DIV_WIDTH-1:0] divisor;
    logic                 mt_hi;
    logic                 mt_lo;
    logic [DIV_WIDTH-1:0] mt_data;
    logic                 busy;
    logic                 done;
    logic                 div_by_zero;
    logic [DIV_WIDTH-1:0] hi;
    logic [DIV_WIDTH-1:0] lo;

    modport master (
        output start, is_signed, dividend, divisor, mt_hi, mt_lo, mt_data,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, is_signed, dividend, divisor, mt_hi, mt_lo, mt_data,
        output busy, done, div_by_zero, hi, lo
    );

endinterface

// File: rtl/mips_div_sequencer_div_step.sv
// One radix-2^BITS restoring divide step: shifts BITS dividend bits into the partial remainder.
// Combinational; the 33-bit compare absorbs the carry out of the shifted remainder.
module mips_div_sequencer_div_step
    import mips_div_sequencer_pkg::*;
#(
    parameter int BITS = 1
) (
    input  logic [DIV_WIDTH-1:0] rem_in,
    input  logic [BITS-1:0]      bits_in,
    input  logic [DIV_WIDTH-1:0] divisor,
    output logic [DIV_WIDTH-1:0] rem_out,
    output logic [BITS-1:0]      q_out
);

    logic [DIV_WIDTH:0]   trial;
    logic [DIV_WIDTH-1:0] part;

    always_comb begin
        q_out = '0;
        trial = '0;
        part  = rem_in;
        for (int i = BITS - 1; i >= 0; i--) begin
            trial = {part, bits_in[i]};
            if (trial >= {1'b0, divisor}) begin
                trial    = trial - {1'b0, divisor};
                q_out[i] = 1'b1;
            end
            part = trial[DIV_WIDTH-1:0];
        end
        rem_out = part;
    end

endmodule

// File: rtl/mips_div_sequencer.sv
// Multicycle DIV/DIVU sequencer: restoring divider on magnitudes, MIPS sign fix, results into HI/LO.
// Latency ITERS+2 edges from accepted start to done; start and MTHI/MTLO are ignored while busy.
module mips_div_sequencer
    import mips_div_sequencer_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1   // 1, 2 or 4
) (
    input logic                 clk,
    input logic                 reset,
    mips_div_sequencer_if.slave bus
);

    localparam int ITERS = DIV_WIDTH / BITS_PER_CYCLE;
    localparam logic [5:0] LAST_ITER = 6'(ITERS - 1);

    div_state_t           state;
    div_state_t           state_nxt;
    logic                 accept;
    logic                 idle_like;
    logic [5:0]           count;
    logic [DIV_WIDTH-1:0] dvd_raw;
    logic [DIV_WIDTH-1:0] dvs;
    logic [DIV_WIDTH-1:0] rem;
    logic [DIV_WIDTH-1:0] quo;
    logic                 sgn;
    logic                 q_neg;
    logic                 r_neg;
    logic                 dvs_zero;
    logic                 busy_r;
    logic                 done_r;
    logic                 dbz_r;
    logic [DIV_WIDTH-1:0] hi_r;
    logic [DIV_WIDTH-1:0] lo_r;

    logic [DIV_WIDTH-1:0]      step_rem;
    logic [BITS_PER_CYCLE-1:0] step_q;

    mips_div_sequencer_div_step #(
        .BITS (BITS_PER_CYCLE)
    ) u_step (
        .rem_in  (rem),
        .bits_in (quo[DIV_WIDTH-1 -: BITS_PER_CYCLE]),
        .divisor (dvs),
        .rem_out (step_rem),
        .q_out   (step_q)
    );

    assign idle_like = (state == IDLE) || (state == DONE);

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_nxt = PREP;
                    accept    = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            PREP:    state_nxt = ITER;
            ITER:    state_nxt = (count == LAST_ITER) ? FIX : ITER;
            FIX:     state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            dvd_raw  <= '0;
            dvs      <= '0;
            rem      <= '0;
            quo      <= '0;
            sgn      <= 1'b0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            dvs_zero <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            dbz_r    <= 1'b0;
            hi_r     <= '0;
            lo_r     <= '0;
        end else begin
            state  <= state_nxt;
            busy_r <= (state_nxt == PREP) || (state_nxt == ITER) || (state_nxt == FIX);
            done_r <= (state == FIX);

            if (accept) begin
                dvd_raw  <= bus.dividend;
                dvs      <= bus.divisor;
                sgn      <= bus.is_signed;
                q_neg    <= bus.is_signed & (bus.dividend[DIV_WIDTH-1] ^ bus.divisor[DIV_WIDTH-1]);
                r_neg    <= bus.is_signed & bus.dividend[DIV_WIDTH-1];
                dvs_zero <= (bus.divisor == '0);
                dbz_r    <= 1'b0;
            end

            // A same-cycle start still lets MTHI/MTLO land; the result overwrites them later.
            if (idle_like) begin
                if (bus.mt_hi) hi_r <= bus.mt_data;
                if (bus.mt_lo) lo_r <= bus.mt_data;
            end

            case (state)
                PREP: begin
                    quo   <= cond_neg(dvd_raw, sgn & dvd_raw[DIV_WIDTH-1]);
                    dvs   <= cond_neg(dvs, sgn & dvs[DIV_WIDTH-1]);
                    rem   <= '0;
                    count <= '0;
                end
                ITER: begin
                    rem   <= step_rem;
                    quo   <= {quo[DIV_WIDTH-1-BITS_PER_CYCLE:0], step_q};
                    count <= count + 1'b1;
                end
                FIX: begin
                    if (dvs_zero) begin
                        lo_r  <= DIV_BY_ZERO_Q;
                        hi_r  <= dvd_raw;
                        dbz_r <= 1'b1;
                    end else begin
                        lo_r <= cond_neg(quo, q_neg);
                        hi_r <= cond_neg(rem, r_neg);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.div_by_zero = dbz_r;
    assign bus.hi          = hi_r;
    assign bus.lo          = lo_r;

endmodule
